// File: rtl/mdu_multicycle.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Multiplies by shift-add and divides by restoring steps on operand magnitudes, then fixes up the signs.
module mdu_multicycle #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t state, state_next;

    logic             is_div;
    logic             neg_a, neg_b, div_zero;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, low, opd;

    logic [WIDTH:0]     mul_sum, div_shift, div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN:  if (cnt == LAST) state_next = S_FIN;
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand magnitudes; 0x80000000 negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    always_comb begin
        mul_sum   = low[0] ? ({1'b0, acc} + {1'b0, opd}) : {1'b0, acc};
        div_shift = {acc, low[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opd};
        div_rem   = div_ge ? (div_shift - {1'b0, opd}) : div_shift;
        prod      = {acc, low};
        prod_fix  = (neg_a ^ neg_b) ? -prod : prod;
        quo_fix   = div_zero ? {WIDTH{1'b1}} : ((neg_a ^ neg_b) ? -low : low);
        rem_fix   = neg_a ? -acc : acc;
    end

    // acc/low hold {product high, multiplier} for multiply and {remainder, quotient} for divide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            low      <= '0;
            opd      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        neg_a    <= a_neg;
                        neg_b    <= b_neg;
                        div_zero <= (b == '0);
                        acc      <= '0;
                        low      <= a_mag;
                        opd      <= b_mag;
                        cnt      <= '0;
                        busy     <= 1'b1;
                    end else begin
                        if (hi_we) hi <= wd;
                        if (lo_we) lo <= wd;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc <= div_rem[WIDTH-1:0];
                        low <= {low[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        low <= {mul_sum[0], low[WIDTH-1:1]};
                    end
                end
                S_FIN: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: directed vector table, corner-case sequences
// and randomized operations compared against an arithmetic reference model.
module tb_mdu_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mdu_multicycle #(.WIDTH(32), .ITER(32)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wd   (wd),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    // Reference result {hi, lo} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] r, q, m;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = '0;
        case (o)
            2'd0: r = 64'(sx * sy);
            2'd1: r = {32'b0, x} * {32'b0, y};
            2'd2: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else begin
                    q = 64'(sx / sy);
                    m = 64'(sx % sy);
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t        vecs[8];
    int          lat;
    int          done_seen;
    logic [63:0] exp;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    initial begin
        vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'd3, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
        vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};

        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_hi", hi, 32'h0);
        check_output("reset_lo", lo, 32'h0);
        check_output("reset_busy", {31'b0, busy}, 32'h0);
        check_output("reset_done", {31'b0, done}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            check_output($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'h1);
            wait_done(lat);
            check_output($sformatf("vec%0d_latency", i), lat, 33);
            check_output($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check_output($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d_done_drop", i), {31'b0, done}, 32'h0);
        end

        // IDLE writes, start beating a same-edge write, writes ignored while busy, write in done cycle.
        hi_we = 1'b1; wd = 32'hA5A5A5A5;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wd = 32'h5A5A5A5A;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check_output("wr_hi", hi, 32'hA5A5A5A5);
        check_output("wr_lo", lo, 32'h5A5A5A5A);
        hi_we = 1'b1; wd = 32'hDEADBEEF;
        apply_stimulus(2'd1, 32'd7, 32'd9);
        hi_we = 1'b0;
        check_output("start_wins_hi", hi, 32'hA5A5A5A5);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h11111111;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check_output("busy_wr_hi", hi, 32'hA5A5A5A5);
        check_output("busy_wr_lo", lo, 32'h5A5A5A5A);
        wait_done(lat);
        check_output("sw_latency", lat, 32);
        check_output("sw_hi", hi, 32'd0);
        check_output("sw_lo", lo, 32'd63);
        lo_we = 1'b1; wd = 32'h0BADF00D;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check_output("done_cycle_lo", lo, 32'h0BADF00D);
        check_output("done_cycle_hi", hi, 32'd0);

        // Second start during an operation is ignored.
        apply_stimulus(2'd1, 32'd7, 32'd9);
        repeat (9) begin @(posedge clk); #1; end
        op = 2'd3; a = 32'd100; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check_output("ignore_latency", lat, 23);
        check_output("ignore_hi", hi, 32'd0);
        check_output("ignore_lo", lo, 32'd63);

        // Reset in the middle of an operation.
        apply_stimulus(2'd0, 32'hFFFFFFFD, 32'd5);
        repeat (11) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check_output("midrst_hi", hi, 32'd0);
        check_output("midrst_lo", lo, 32'd0);
        check_output("midrst_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        check_output("midrst_no_done", done_seen, 0);
        check_output("midrst_hi_after", hi, 32'd0);
        apply_stimulus(2'd3, 32'd100, 32'd7);
        wait_done(lat);
        check_output("post_rst_latency", lat, 33);
        check_output("post_rst_hi", hi, 32'd2);
        check_output("post_rst_lo", lo, 32'd14);

        // Randomized back-to-back operations; each new start lands on E34.
        for (int i = 0; i < 30; i++) begin
            r_op = 2'($urandom);
            case ($urandom_range(0, 7))
                0: begin r_a = $urandom; r_b = 32'd0; end
                1: begin r_a = 32'h80000000; r_b = 32'hFFFFFFFF; end
                2: begin
                    r_a = $urandom_range(0, 300);
                    r_b = $urandom_range(1, 20);
                    if ($urandom_range(0, 1) == 1) r_a = -r_a;
                    if ($urandom_range(0, 1) == 1) r_b = -r_b;
                end
                default: begin r_a = $urandom; r_b = $urandom; end
            endcase
            exp = ref_model(r_op, r_a, r_b);
            apply_stimulus(r_op, r_a, r_b);
            wait_done(lat);
            check_output($sformatf("rnd%0d_latency op=%0d a=%h b=%h", i, r_op, r_a, r_b), lat, 33);
            check_output($sformatf("rnd%0d_hi op=%0d a=%h b=%h", i, r_op, r_a, r_b), hi, exp[63:32]);
            check_output($sformatf("rnd%0d_lo op=%0d a=%h b=%h", i, r_op, r_a, r_b), lo, exp[31:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
Iterative multiply/divide unit for the EX stage, placed next to alu. It takes the two register-file read operands, rd1 and rd2, on its a and b inputs. It executes mult, multu, div and divu over 33 cycles and holds the results in internal HI/LO registers. mfhi/mflo read those registers, and mthi/mtlo write them. busy is the stall source for the hazard logic.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported.
ITER, 32, number of iteration cycles; must equal WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled on the rising edge
op  input  2  00 mult, 01 multu, 10 div, 11 divu
a  input  32  source operand (rs): multiplicand or dividend
b  input  32  source operand (rt): multiplier or divisor
hi_we  input  1  mthi write enable
lo_we  input  1  mtlo write enable
wd  input  32  data for mthi/mtlo
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO have just been updated by an operation
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - hi, lo, busy and done are all 0.
  - Internal accumulator and counter are cleared.
  - Reset in the middle of an operation aborts it; no partial result reaches hi/lo.
- States: IDLE, RUN, FIN. All outputs are registered.
- IDLE:
  - On an edge with start=1:
    - Latch op.
    - Latch |a| and |b| for signed ops, or a and b unchanged for unsigned ops.
    - Record the result signs.
    - Clear the counter, set busy=1, go to RUN.
  - Otherwise, hi_we loads hi<=wd and lo_we loads lo<=wd; the two are independent.
- RUN:
  - Each edge performs one iteration:
    - Multiply: shift-add on a 64-bit {acc, multiplier} register.
    - Divide: restoring step on {remainder, quotient}.
  - The counter increments each edge. After the 32nd iteration edge, go to FIN.
- FIN:
  - One edge applies the sign correction and writes hi/lo.
  - On that same edge: busy<=0, done<=1, go to IDLE.
  - done drops on the next edge.
- Latency:
  - Call the start edge E0; busy is high from E0 until E33.
  - hi/lo are valid, and done=1, in the cycle after E33.
  - A new start can be accepted at E34 at the earliest.
- Results:
  - mult/multu: {hi,lo} = the 64-bit product. Signed product is negated when the operand signs differ.
  - div/divu: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Boundary conditions:
  - Divide by zero (div or divu): lo = 0xFFFFFFFF, hi = a (the original, unmodified dividend).
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Signed magnitude of 0x80000000 is 0x80000000, handled as an unsigned 33-bit value internally.
- Simultaneous events and conflicts:
  - start while busy=1: ignored; the operation in progress is unaffected.
  - hi_we/lo_we while busy=1: ignored.
  - In IDLE with start and hi_we/lo_we on the same edge: start wins and the write is dropped.
  - hi_we/lo_we in the cycle where done=1 (state IDLE): the write is applied normally.
- Operand timing: a, b and op are don't-care after E0.

Test Plan:
- multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- mult, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. div, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu, a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Sequence of writes and a start:
  - hi_we with wd=0xA5A5A5A5, then lo_we with wd=0x5A5A5A5A in IDLE -> hi/lo hold those values.
  - start=1 together with hi_we=1 -> the write is dropped and the operation result appears at done.
- Start multu 7*9, then pulse start with divu 100/3 at cycle 10 -> second start ignored; lo=63, hi=0 after E33.
- Start mult, assert reset at cycle 12 -> hi=lo=0, busy=0, done never pulses. After release, divu 100/7 -> lo=14, hi=2.
